// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file and its clear sequencer.
// Holds the sweep state encoding so the sequencer and any observers agree on it.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NREAD = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequential clear sweep: one entry zeroed per cycle for DEPTH cycles, starting the edge after clear.
// No backpressure; clear requests arriving while a sweep is running are ignored.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          busy,
    output logic          zero_en,
    output logic [AW-1:0] idx
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    sweep_state_t  state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    // Last entry is zeroed on this edge; return to IDLE with the counter wrapped.
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy    = (state == SWEEP);
    assign zero_en = (state == SWEEP);
    assign idx     = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending bits, optional write bypass and a clear sweep.
// Reads are combinational; writes/claims commit on the rising edge and are dropped while sweeping.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NREAD  = DEF_NREAD,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   we_in,
    input  logic                   wr_inhibit_in,
    input  logic [AW-1:0]          wr_addr_in,
    input  logic [WIDTH-1:0]       wr_data_in,
    input  logic [NREAD*AW-1:0]    rd_addr_in,
    output logic [NREAD*WIDTH-1:0] rd_data_out,
    output logic [NREAD-1:0]       rd_pend_out,
    input  logic                   claim_in,
    input  logic [AW-1:0]          claim_addr_in,
    output logic [DEPTH-1:0]       pend_out,
    input  logic                   clear_in,
    output logic                   clear_busy_out,
    output logic [WIDTH-1:0]       reg0_out
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;

    logic          sweep_busy;
    logic          sweep_zero;
    logic [AW-1:0] sweep_idx;
    logic          wr_commit;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk     (clk_in),
        .rst_n   (reset_n_in),
        .clear   (clear_in),
        .busy    (sweep_busy),
        .zero_en (sweep_zero),
        .idx     (sweep_idx)
    );

    // The inhibit input holds off writes during the PC-latch phase.
    assign wr_commit = we_in && !wr_inhibit_in && !sweep_busy;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else if (sweep_zero) begin
            mem[sweep_idx]  <= '0;
            pend[sweep_idx] <= 1'b0;
        end else begin
            if (wr_commit) begin
                mem[wr_addr_in]  <= wr_data_in;
                pend[wr_addr_in] <= 1'b0;
            end
            // Placed after the write so a same-edge claim on the same entry leaves it pending.
            if (claim_in) begin
                pend[claim_addr_in] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = rd_addr_in[p*AW +: AW];
        assign hit = (BYPASS != 0) && wr_commit && (wr_addr_in == ra);
        assign rd_data_out[p*WIDTH +: WIDTH] = hit ? wr_data_in : mem[ra];
        assign rd_pend_out[p] = pend[ra];
    end

    assign pend_out       = pend;
    assign clear_busy_out = sweep_busy;
    assign reg0_out       = mem[0];

endmodule
